fir_axis_scheduler: RTL and testbench

//  Time-multiplexes the single accelerometer FIR core between X and Y axes. Generates the

---
 rtl/fir_axis_scheduler_pkg.sv | 23 ++
 rtl/fir_axis_scheduler_if.sv | 26 ++
 rtl/fir_axis_scheduler_sample_tick_gen.sv | 36 +++
 rtl/fir_axis_scheduler.sv | 146 ++++++++++++++
 tb/tb_fir_axis_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_axis_scheduler_pkg.sv
// Shared types for the X/Y FIR time-multiplexing scheduler.
//   state_t        : scheduler FSM states
//   axis_t         : FIR bank select (X = 0, Y = 1)
//   DATA_W_DEFAULT : default sample / FIR word width
package fir_sched_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    WAIT_X,
    LOAD_Y,
    WAIT_Y,
    PUBLISH
  } state_t;

  typedef enum logic {
    AXIS_X = 1'b0,
    AXIS_Y = 1'b1
  } axis_t;

endpackage

// File: rtl/fir_axis_scheduler_if.sv
// Start/done handshake between the scheduler and the shared FIR core.
//   fir_in    : word to filter, stable from LOAD through WAIT
//   fir_sel   : delay-line bank select (0 = X, 1 = Y)
//   fir_start : 1-cycle pulse, FIR begins on fir_in
//   fir_done  : FIR result valid on fir_out this cycle
//   fir_out   : FIR result
// master = scheduler side, slave = FIR core side.
interface fir_axis_scheduler_if
  import fir_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic [DATA_W-1:0] fir_in;
  logic              fir_sel;
  logic              fir_start;
  logic              fir_done;
  logic [DATA_W-1:0] fir_out;

  modport master (output fir_in, output fir_sel, output fir_start,
                  input  fir_done, input fir_out);

  modport slave  (input  fir_in, input fir_sel, input fir_start,
                  output fir_done, output fir_out);

endinterface

// File: rtl/fir_axis_scheduler_sample_tick_gen.sv
// Sample-rate divider for the FIR scheduler.
//   clk      : system clock
//   reset    : synchronous, active-high
//   enable   : 0 holds the divider at 0 (no ticks)
//   tick_raw : high while enabled and the divider sits at DIV-1
module sample_tick_gen #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick_raw
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  if (DIV < 16) begin : g_div_check
    $error("sample_tick_gen: DIV must be at least 16");
  end

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_raw = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/fir_axis_scheduler.sv
// Time-multiplexes one FIR core between the X and Y accelerometer axes.
// Each accepted sample tick snapshots the latest raw X/Y pair, runs X then Y
// through the FIR with a start/done handshake, and publishes the filtered pair.
//   clk, reset          : system clock, synchronous active-high reset
//   enable              : 0 = no sample ticks
//   clear_err           : clears sticky overrun / timeout_err
//   raw_valid, raw_x/y  : raw sample update from the SPI reader
//   sample_tick         : 1-cycle pulse on an accepted frame start
//   fir                 : handshake to the shared FIR core (master side)
//   out_x, out_y        : filtered results, held between frames
//   out_valid           : 1-cycle pulse when out_x/out_y update
//   overrun             : sticky, a tick arrived while a frame was busy
//   timeout_err         : sticky, fir_done missing within FIR_TIMEOUT cycles
//
// state   | meaning
// IDLE    | waiting for a tick; snapshot taken on the accepting edge
// LOAD_X  | fir_start pulse with the X snapshot
// WAIT_X  | waiting for fir_done (or timeout) on X
// LOAD_Y  | fir_start pulse with the Y snapshot
// WAIT_Y  | waiting for fir_done (or timeout) on Y
// PUBLISH | copy results to out_x/out_y, raise out_valid next cycle
module fir_axis_scheduler
  import fir_sched_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int CLK_HZ      = 50_000_000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int FIR_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_err,
  input  logic                 raw_valid,
  input  logic [DATA_W-1:0]    raw_x,
  input  logic [DATA_W-1:0]    raw_y,
  output logic                 sample_tick,
  fir_axis_scheduler_if.master fir,
  output logic [DATA_W-1:0]    out_x,
  output logic [DATA_W-1:0]    out_y,
  output logic                 out_valid,
  output logic                 overrun,
  output logic                 timeout_err
);

  localparam int DIV    = CLK_HZ / SAMPLE_HZ;
  localparam int WAIT_W = $clog2(FIR_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(FIR_TIMEOUT);

  state_t            state;
  logic              tick_raw;
  logic [DATA_W-1:0] hold_x, hold_y, snap_y, res_x, res_y;
  logic [WAIT_W-1:0] wait_cnt, wait_inc;
  logic              wait_hit, in_wait, new_ovr, new_tmo;

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .tick_raw (tick_raw)
  );

  assign sample_tick = tick_raw && (state == IDLE);
  assign wait_inc    = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + WAIT_W'(1);
  assign wait_hit    = (wait_inc == WAIT_LIMIT);
  assign in_wait     = (state == WAIT_X) || (state == WAIT_Y);
  assign new_ovr     = tick_raw && (state != IDLE);
  // done on the last allowed cycle still counts as success
  assign new_tmo     = in_wait && !fir.fir_done && wait_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      hold_x        <= '0;
      hold_y        <= '0;
      snap_y        <= '0;
      res_x         <= '0;
      res_y         <= '0;
      wait_cnt      <= '0;
      fir.fir_in    <= '0;
      fir.fir_sel   <= AXIS_X;
      fir.fir_start <= 1'b0;
      out_x         <= '0;
      out_y         <= '0;
      out_valid     <= 1'b0;
      overrun       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if (raw_valid) begin
        hold_x <= raw_x;
        hold_y <= raw_y;
      end
      fir.fir_start <= 1'b0;
      out_valid     <= 1'b0;
      // a new error in the clearing cycle keeps the flag set
      overrun     <= (overrun && !clear_err) || new_ovr;
      timeout_err <= (timeout_err && !clear_err) || new_tmo;

      case (state)
        IDLE: begin
          if (tick_raw) begin
            // X goes straight from hold so fir_in is valid in the LOAD_X cycle
            fir.fir_in    <= hold_x;
            fir.fir_sel   <= AXIS_X;
            fir.fir_start <= 1'b1;
            snap_y        <= hold_y;
            state         <= LOAD_X;
          end
        end
        LOAD_X: begin
          wait_cnt <= '0;
          state    <= WAIT_X;
        end
        WAIT_X: begin
          wait_cnt <= wait_inc;
          if (fir.fir_done || wait_hit) begin
            if (fir.fir_done) res_x <= fir.fir_out;
            fir.fir_in    <= snap_y;
            fir.fir_sel   <= AXIS_Y;
            fir.fir_start <= 1'b1;
            state         <= LOAD_Y;
          end
        end
        LOAD_Y: begin
          wait_cnt <= '0;
          state    <= WAIT_Y;
        end
        WAIT_Y: begin
          wait_cnt <= wait_inc;
          if (fir.fir_done || wait_hit) begin
            if (fir.fir_done) res_y <= fir.fir_out;
            state <= PUBLISH;
          end
        end
        PUBLISH: begin
          out_x     <= res_x;
          out_y     <= res_y;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_axis_scheduler.sv
module tb_fir_axis_scheduler;
  import fir_sched_pkg::*;

  localparam int DW = 32;
  localparam int CLK_HZ = 1600;
  localparam int SAMPLE_HZ = 100;
  localparam int FIR_TIMEOUT = 255;
  localparam int DIV = CLK_HZ / SAMPLE_HZ;

  logic clk = 1'b0;
  logic reset, enable, clear_err, raw_valid;
  logic [DW-1:0] raw_x, raw_y, out_x, out_y;
  logic sample_tick, out_valid, overrun, timeout_err;

  fir_axis_scheduler_if #(.DATA_W(DW)) fir_if ();

  fir_axis_scheduler #(
    .DATA_W(DW), .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .FIR_TIMEOUT(FIR_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
    .raw_valid(raw_valid), .raw_x(raw_x), .raw_y(raw_y),
    .sample_tick(sample_tick), .fir(fir_if.master),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // FIR core model: done 'fir_delay' cycles after start, out = in + 1
  int fir_delay = 3;
  bit hang_x = 1'b0;
  bit inject_done = 1'b0;
  bit m_busy = 1'b0;
  int m_rem = 0;
  logic [DW-1:0] m_val = '0;
  logic m_done = 1'b0;
  logic [DW-1:0] m_out = '0;
  assign fir_if.fir_done = m_done;
  assign fir_if.fir_out  = m_out;

  always @(negedge clk) begin
    m_done = 1'b0;
    if (inject_done) begin
      m_done = 1'b1;
      m_out  = $urandom;
    end else if (m_busy) begin
      m_rem = m_rem - 1;
      if (m_rem == 0) begin
        m_done = 1'b1;
        m_out  = m_val;
        m_busy = 1'b0;
      end
    end
    if (fir_if.fir_start === 1'b1) begin
      m_busy = !(hang_x && fir_if.fir_sel == 1'b0);
      m_rem  = fir_delay;
      m_val  = fir_if.fir_in + 1;
    end
  end

  // event logs
  typedef struct { int c; logic [DW-1:0] a; logic [DW-1:0] b; } ev_t;
  int  tick_q[$];
  ev_t start_q[$];
  ev_t out_q[$];

  always @(negedge clk) begin
    ev_t ev;
    if (sample_tick === 1'b1) tick_q.push_back(cyc);
    if (fir_if.fir_start === 1'b1) begin
      ev.c = cyc; ev.a = fir_if.fir_in; ev.b = DW'(fir_if.fir_sel);
      start_q.push_back(ev);
    end
    if (out_valid === 1'b1) begin
      ev.c = cyc; ev.a = out_x; ev.b = out_y;
      out_q.push_back(ev);
    end
  end

  // reference state
  logic [DW-1:0] ref_hold_x = '0, ref_hold_y = '0, ref_out_x = '0, ref_out_y = '0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic clear_logs();
    tick_q.delete();
    start_q.delete();
    out_q.delete();
  endtask

  task automatic strobe_raw(input logic [DW-1:0] x, input logic [DW-1:0] y);
    raw_x = x; raw_y = y; raw_valid = 1'b1;
    step();
    raw_valid = 1'b0;
    ref_hold_x = x; ref_hold_y = y;
  endtask

  task automatic wait_tick(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (sample_tick === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Frame timeline from the handshake rules; d < 0 means the FIR never answers.
  task automatic model_frame(input int t, input int dx, input int dy,
                             output int sx, output int sy, output int ov,
                             output logic [DW-1:0] ex, output logic [DW-1:0] ey);
    sx = t + 1;
    sy = sx + ((dx < 0) ? FIR_TIMEOUT : dx) + 1;
    ov = sy + ((dy < 0) ? FIR_TIMEOUT : dy) + 2;
    ex = (dx < 0) ? ref_out_x : ref_hold_x + 1;
    ey = (dy < 0) ? ref_out_y : ref_hold_y + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; raw_valid = 1'b0; raw_x = '0; raw_y = '0;
    repeat (3) step();
    total++; if (sample_tick !== 1'b0) begin bad++; $display("FAIL reset_sample_tick: got %b want 0", sample_tick); end
    total++; if (fir_if.fir_start !== 1'b0) begin bad++; $display("FAIL reset_fir_start: got %b want 0", fir_if.fir_start); end
    total++; if (fir_if.fir_in !== '0) begin bad++; $display("FAIL reset_fir_in: got %h want 0", fir_if.fir_in); end
    total++; if (fir_if.fir_sel !== 1'b0) begin bad++; $display("FAIL reset_fir_sel: got %b want 0", fir_if.fir_sel); end
    total++; if ({out_x, out_y} !== '0) begin bad++; $display("FAIL reset_out: got %h/%h want 0/0", out_x, out_y); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({overrun, timeout_err} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b%b want 00", overrun, timeout_err); end
    reset = 1'b0;
    clear_logs();
    repeat (3 * DIV) step();
    total++; if (tick_q.size() != 0) begin bad++; $display("FAIL disabled_no_tick: got %0d ticks want 0", tick_q.size()); end
  endtask

  task automatic test_basic();
    int e, t, sx, sy, ov;
    logic [DW-1:0] ex, ey;
    fir_delay = 3;
    for (int f = 0; f < 3; f++) begin
      clear_logs();
      strobe_raw($urandom, $urandom);
      enable = 1'b1; e = cyc;
      wait_tick(2 * DIV, t);
      step(); enable = 1'b0;
      total++; if (t != e + DIV - 1) begin bad++; $display("FAIL basic_tick_time f%0d: got %0d want %0d", f, t, e + DIV - 1); end
      model_frame(t, 3, 3, sx, sy, ov, ex, ey);
      run_until(ov + 3);
      total++; if (start_q.size() != 2) begin bad++; $display("FAIL basic_start_count f%0d: got %0d want 2", f, start_q.size()); end
      if (start_q.size() == 2) begin
        total++;
        if (start_q[0].c != sx || start_q[0].a !== ref_hold_x || start_q[0].b !== '0) begin
          bad++; $display("FAIL basic_start_x f%0d: got c%0d %h sel%0d want c%0d %h sel0", f, start_q[0].c, start_q[0].a, start_q[0].b, sx, ref_hold_x);
        end
        total++;
        if (start_q[1].c != sy || start_q[1].a !== ref_hold_y || start_q[1].b !== 1) begin
          bad++; $display("FAIL basic_start_y f%0d: got c%0d %h sel%0d want c%0d %h sel1", f, start_q[1].c, start_q[1].a, start_q[1].b, sy, ref_hold_y);
        end
      end
      total++; if (out_q.size() != 1) begin bad++; $display("FAIL basic_out_count f%0d: got %0d want 1", f, out_q.size()); end
      if (out_q.size() == 1) begin
        total++;
        if (out_q[0].c != ov || out_q[0].a !== ex || out_q[0].b !== ey) begin
          bad++; $display("FAIL basic_out f%0d: got c%0d %h/%h want c%0d %h/%h", f, out_q[0].c, out_q[0].a, out_q[0].b, ov, ex, ey);
        end
      end
      total++; if (out_x !== ex || out_y !== ey) begin bad++; $display("FAIL basic_hold f%0d: got %h/%h want %h/%h", f, out_x, out_y, ex, ey); end
      ref_out_x = ex; ref_out_y = ey;
    end
  endtask

  task automatic test_overrun();
    int t, t2, sx, sy, ov, ov2;
    logic [DW-1:0] ex, ey;
    fir_delay = 20;
    clear_logs();
    strobe_raw($urandom, $urandom);
    enable = 1'b1;
    wait_tick(2 * DIV, t);
    model_frame(t, 20, 20, sx, sy, ov, ex, ey);
    t2 = t;
    while (t2 <= ov) t2 += DIV;
    while (cyc < t2 + 1) begin
      step();
      clear_err = (cyc == t + DIV + 1) || (cyc == t + 2 * DIV);
      if (cyc == t + DIV + 1) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
      end
      if (cyc == t + DIV + 2) begin
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear: got %b want 0", overrun); end
      end
      if (cyc == t + 2 * DIV + 1) begin
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set_wins: got %b want 1", overrun); end
      end
    end
    clear_err = 1'b0; enable = 1'b0;
    ref_out_x = ex; ref_out_y = ey;
    model_frame(t2, 20, 20, sx, sy, ov2, ex, ey);
    run_until(ov2 + 3);
    total++;
    if (tick_q.size() != 2 || (tick_q.size() == 2 && (tick_q[0] != t || tick_q[1] != t2))) begin
      bad++; $display("FAIL overrun_ticks: got %0d ticks want 2 at %0d,%0d", tick_q.size(), t, t2);
    end
    total++;
    if (start_q.size() != 4 || (start_q.size() == 4 && start_q[2].c != t2 + 1)) begin
      bad++; $display("FAIL overrun_no_restart: got %0d starts want 4 (3rd at %0d)", start_q.size(), t2 + 1);
    end
    total++;
    if (out_q.size() != 2 || (out_q.size() == 2 && (out_q[0].c != ov || out_q[1].c != ov2))) begin
      bad++; $display("FAIL overrun_out_valid: got %0d pulses want 2 at %0d,%0d", out_q.size(), ov, ov2);
    end
    ref_out_x = ex; ref_out_y = ey;
    clear_err = 1'b1; step(); clear_err = 1'b0; step();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_final_clear: got %b want 0", overrun); end
    fir_delay = 3;
  endtask

  task automatic test_timeout();
    int t, sx, sy, ov;
    logic [DW-1:0] ex, ey;
    hang_x = 1'b1;
    clear_logs();
    strobe_raw($urandom, $urandom);
    enable = 1'b1;
    wait_tick(2 * DIV, t);
    step(); enable = 1'b0;
    model_frame(t, -1, 3, sx, sy, ov, ex, ey);
    while (cyc < ov + 3) begin
      step();
      if (cyc == sy - 1) begin
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
      end
      if (cyc == sy) begin
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
      end
    end
    total++;
    if (start_q.size() != 2 || (start_q.size() == 2 && (start_q[1].c != sy || start_q[1].a !== ref_hold_y))) begin
      bad++; $display("FAIL timeout_y_start: got %0d starts want Y start at %0d", start_q.size(), sy);
    end
    total++;
    if (out_q.size() != 1 || (out_q.size() == 1 && (out_q[0].c != ov || out_q[0].a !== ex || out_q[0].b !== ey))) begin
      bad++; $display("FAIL timeout_out: got %0d pulses, x=%h y=%h want c%0d %h/%h", out_q.size(), out_x, out_y, ov, ex, ey);
    end
    ref_out_x = ex; ref_out_y = ey;
    hang_x = 1'b0;
    clear_err = 1'b1; step(); clear_err = 1'b0; step();
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL timeout_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_same_cycle_raw();
    int e, t, sx, sy, ov;
    logic [DW-1:0] ex, ey, nx, ny;
    nx = $urandom; ny = $urandom;
    for (int f = 0; f < 2; f++) begin
      clear_logs();
      enable = 1'b1; e = cyc;
      run_until(e + DIV - 1);
      if (f == 0) begin
        raw_x = nx; raw_y = ny; raw_valid = 1'b1;
      end
      step(); raw_valid = 1'b0; enable = 1'b0;
      t = (tick_q.size() > 0) ? tick_q[0] : -1;
      total++; if (t != e + DIV - 1) begin bad++; $display("FAIL raw_tick f%0d: got %0d want %0d", f, t, e + DIV - 1); end
      model_frame(t, 3, 3, sx, sy, ov, ex, ey);
      run_until(ov + 3);
      total++;
      if (start_q.size() != 2 || (start_q.size() == 2 && start_q[0].a !== ref_hold_x)) begin
        bad++; $display("FAIL raw_snapshot f%0d: got %0d starts, fir_in=%h want %h", f, start_q.size(), (start_q.size() > 0) ? start_q[0].a : '0, ref_hold_x);
      end
      total++; if (out_x !== ex || out_y !== ey) begin bad++; $display("FAIL raw_out f%0d: got %h/%h want %h/%h", f, out_x, out_y, ex, ey); end
      ref_out_x = ex; ref_out_y = ey;
      if (f == 0) begin ref_hold_x = nx; ref_hold_y = ny; end
    end
  endtask

  task automatic test_reset_midframe();
    int t, t2, rel, sx, sy, ov;
    logic [DW-1:0] ex, ey;
    fir_delay = 20;
    clear_logs();
    strobe_raw($urandom, $urandom);
    enable = 1'b1;
    wait_tick(2 * DIV, t);
    run_until(t + 5);
    reset = 1'b1;
    step();
    total++;
    if ({sample_tick, fir_if.fir_start, fir_if.fir_in, fir_if.fir_sel, out_x, out_y, out_valid, overrun, timeout_err} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got start=%b in=%h sel=%b out=%h/%h ov=%b err=%b%b want all 0", fir_if.fir_start, fir_if.fir_in, fir_if.fir_sel, out_x, out_y, out_valid, overrun, timeout_err);
    end
    reset = 1'b0; rel = cyc;
    ref_hold_x = '0; ref_hold_y = '0; ref_out_x = '0; ref_out_y = '0;
    wait_tick(2 * DIV, t2);
    step(); enable = 1'b0;
    total++; if (t2 != rel + DIV - 1) begin bad++; $display("FAIL midreset_tick_resume: got %0d want %0d", t2, rel + DIV - 1); end
    model_frame(t2, 20, 20, sx, sy, ov, ex, ey);
    run_until(ov + 3);
    total++;
    if (out_q.size() != 1 || (out_q.size() == 1 && (out_q[0].c != ov || out_q[0].a !== ex || out_q[0].b !== ey))) begin
      bad++; $display("FAIL midreset_out: got %0d pulses x=%h y=%h want 1 at c%0d %h/%h", out_q.size(), out_x, out_y, ov, ex, ey);
    end
    ref_out_x = ex; ref_out_y = ey;
    fir_delay = 3;
  endtask

  task automatic test_enable_gap();
    int e, t, sx, sy, ov;
    logic [DW-1:0] ex, ey;
    clear_logs();
    enable = 1'b1;
    repeat ($urandom_range(3, 12)) step();
    enable = 1'b0;
    repeat ($urandom_range(1, 5)) step();
    inject_done = 1'b1; step(); inject_done = 1'b0;
    repeat (3) step();
    total++;
    if (tick_q.size() != 0 || start_q.size() != 0 || out_q.size() != 0) begin
      bad++; $display("FAIL gap_spurious: got ticks=%0d starts=%0d outs=%0d want 0/0/0", tick_q.size(), start_q.size(), out_q.size());
    end
    total++; if (out_x !== ref_out_x || out_y !== ref_out_y) begin bad++; $display("FAIL gap_out_hold: got %h/%h want %h/%h", out_x, out_y, ref_out_x, ref_out_y); end
    strobe_raw($urandom, $urandom);
    enable = 1'b1; e = cyc;
    wait_tick(2 * DIV, t);
    step(); enable = 1'b0;
    total++; if (t != e + DIV - 1) begin bad++; $display("FAIL gap_tick_time: got %0d want %0d", t, e + DIV - 1); end
    model_frame(t, 3, 3, sx, sy, ov, ex, ey);
    run_until(ov + 3);
    total++;
    if (out_q.size() != 1 || out_x !== ex || out_y !== ey) begin
      bad++; $display("FAIL gap_frame_out: got %0d pulses %h/%h want 1 %h/%h", out_q.size(), out_x, out_y, ex, ey);
    end
    ref_out_x = ex; ref_out_y = ey;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; raw_valid = 1'b0; raw_x = '0; raw_y = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_same_cycle_raw();
    test_reset_midframe();
    test_enable_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
